// File: rtl/key_encoder_8_3.sv
// rtl/key_encoder_8_3.sv - debounced 8-to-3 active-low priority key encoder (optional auto-repeat: ENC_REPEAT_EN)
module key_encoder_8_3 #(
    parameter int DEB_CYCLES    = 16,
    parameter int REPEAT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_n,
    output logic [2:0] code,
    output logic       valid,
    output logic       held,
    output logic       multi
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    // Debounce and repeat counters both rely on these lower bounds.
    if (DEB_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("key_encoder_8_3: DEB_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    logic [7:0]       sync1_q;
    logic [7:0]       s_n_q;
    logic [1:0]       state_q, state_d;
    logic [7:0]       pat_q, pat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [2:0]       code_q, code_d;
    logic             multi_q, multi_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;
    logic             accept;
    logic             rep_fire;
    logic             all_high;

    // Lowest-numbered low line wins.
    function automatic logic [2:0] prio_code(input logic [7:0] p);
        logic [2:0] r;
        r = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (!p[k]) r = 3'(k);
        end
        return r;
    endfunction

    // True when two or more lines are low in the pattern.
    function automatic logic multi_low(input logic [7:0] p);
        int n;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (!p[k]) n++;
        end
        return (n > 1);
    endfunction

    // Two-flop synchroniser; idles at all-ones so reset looks like "nothing pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 8'hFF;
            s_n_q   <= 8'hFF;
        end else begin
            sync1_q <= in_n;
            s_n_q   <= sync1_q;
        end
    end

    assign all_high = (s_n_q == 8'hFF);
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // Press/release state machine with saturating stability counter.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        multi_d = multi_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!all_high) begin
                    pat_d   = s_n_q;
                    cnt_d   = CNT_ONE;
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (all_high) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (s_n_q != pat_q) begin
                    pat_d = s_n_q;
                    cnt_d = CNT_ONE;
                end else if (cnt_inc == CNT_MAX) begin
                    cnt_d   = '0;
                    code_d  = prio_code(pat_q);
                    multi_d = multi_low(pat_q);
                    accept  = 1'b1;
                    state_d = ST_HELD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_HELD: begin
                // Pattern changes while a line is still low are deliberately ignored.
                if (all_high) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                // A low line during release is a bounce: restart the count, never a new press.
                if (!all_high) begin
                    cnt_d = '0;
                end else if (cnt_inc == CNT_MAX) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        endcase
    end

`ifdef ENC_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_q, rep_d;

    // Repeat timer runs only while staying in HELD; cleared on entry and elsewhere.
    always_comb begin
        rep_d    = '0;
        rep_fire = 1'b0;
        if (state_q == ST_HELD && state_d == ST_HELD) begin
            if (rep_q == REP_LAST) begin
                rep_fire = 1'b1;
            end else begin
                rep_d = rep_q + REP_W'(1);
            end
        end
    end

    // Repeat timer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_q <= '0;
        else        rep_q <= rep_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign valid_d = accept | rep_fire;
    assign held_d  = (state_d == ST_HELD) || (state_d == ST_RELEASE);

    // FSM and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pat_q   <= 8'hFF;
            cnt_q   <= '0;
            code_q  <= 3'd0;
            multi_q <= 1'b0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            multi_q <= multi_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign code  = code_q;
    assign multi = multi_q;
    assign valid = valid_q;
    assign held  = held_q;

endmodule

// File: tb/tb_key_encoder_8_3.sv
// tb/tb_key_encoder_8_3.sv - directed self-checking bench for key_encoder_8_3
module tb_key_encoder_8_3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_n = 8'hFF;
    logic [2:0] code;
    logic       valid;
    logic       held;
    logic       multi;

    int n_checks = 0;
    int n_fail   = 0;
    int vcount   = 0;
    int viol     = 0;
    int base     = 0;
    logic prev_v = 1'b0;

    key_encoder_8_3 #(
        .DEB_CYCLES    (4),
        .REPEAT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in_n  (in_n),
        .code  (code),
        .valid (valid),
        .held  (held),
        .multi (multi)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin
            vcount <= vcount + 1;
            if (prev_v) viol <= viol + 1;
        end
        prev_v <= valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        step(3);
        check("rst_code", 32'(code), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_held", 32'(held), 32'd0);
        check("rst_multi", 32'(multi), 32'd0);
        rst_n = 1'b1;
        step(10);
        check("idle_no_valid", 32'(vcount), 32'd0);

        // single press, latency and release
        base = vcount;
        in_n = 8'hF7;
        step(5);
        check("f7_early", 32'(valid), 32'd0);
        step(1);
        check("f7_valid", 32'(valid), 32'd1);
        check("f7_code", 32'(code), 32'd3);
        check("f7_multi", 32'(multi), 32'd0);
        check("f7_held", 32'(held), 32'd1);
        step(1);
        check("f7_strobe_one", 32'(valid), 32'd0);
        step(5);
        check("f7_count", 32'(vcount - base), 32'd1);
        in_n = 8'hFF;
        step(5);
        check("f7_held_late", 32'(held), 32'd1);
        step(1);
        check("f7_held_fall", 32'(held), 32'd0);

        // input bounce during press
        base = vcount;
        for (int i = 0; i < 5; i++) begin
            in_n = 8'hFB;
            step(2);
            in_n = 8'hFF;
            step(2);
        end
        check("bounce_none", 32'(vcount - base), 32'd0);
        in_n = 8'hFB;
        step(5);
        check("fb_early", 32'(valid), 32'd0);
        step(1);
        check("fb_valid", 32'(valid), 32'd1);
        check("fb_code", 32'(code), 32'd2);
        step(6);
        check("fb_count", 32'(vcount - base), 32'd1);
        in_n = 8'hFF;
        step(8);
        check("fb_released", 32'(held), 32'd0);

        // multiple lines low, held pattern change ignored
        base = vcount;
        in_n = 8'h5F;
        step(6);
        check("m_valid", 32'(valid), 32'd1);
        check("m_code", 32'(code), 32'd5);
        check("m_multi", 32'(multi), 32'd1);
        in_n = 8'hBF;
        step(8);
        check("m_change_count", 32'(vcount - base), 32'd1);
        check("m_code_hold", 32'(code), 32'd5);
        check("m_multi_hold", 32'(multi), 32'd1);
        check("m_still_held", 32'(held), 32'd1);
        in_n = 8'hFF;
        step(8);
        check("m_released", 32'(held), 32'd0);
        in_n = 8'hFE;
        step(6);
        check("fe_valid", 32'(valid), 32'd1);
        check("fe_code", 32'(code), 32'd0);
        check("fe_multi", 32'(multi), 32'd0);

        // release bounce
        step(2);
        base = vcount;
        in_n = 8'hFF;
        step(2);
        in_n = 8'hFE;
        step(1);
        in_n = 8'hFF;
        step(5);
        check("rb_held_late", 32'(held), 32'd1);
        step(1);
        check("rb_held_fall", 32'(held), 32'd0);
        check("rb_no_valid", 32'(vcount - base), 32'd0);

        // reset while held, line still low at reset release
        in_n = 8'hFD;
        step(6);
        check("fd_code", 32'(code), 32'd1);
        check("fd_held", 32'(held), 32'd1);
        step(2);
        rst_n = 1'b0;
        #1;
        check("rh_held", 32'(held), 32'd0);
        check("rh_code", 32'(code), 32'd0);
        step(1);
        rst_n = 1'b1;
        base = vcount;
        step(5);
        check("rh_repress_early", 32'(valid), 32'd0);
        step(1);
        check("rh_repress_valid", 32'(valid), 32'd1);
        check("rh_repress_code", 32'(code), 32'd1);
        in_n = 8'hFF;
        step(8);

        // reset mid-debounce
        base = vcount;
        in_n = 8'hF7;
        step(4);
        rst_n = 1'b0;
        #1;
        check("rd_valid", 32'(valid), 32'd0);
        check("rd_held", 32'(held), 32'd0);
        check("rd_code", 32'(code), 32'd0);
        in_n = 8'hFF;
        step(2);
        rst_n = 1'b1;
        step(10);
        check("rd_no_valid", 32'(vcount - base), 32'd0);

        // long hold: single valid, or periodic repeats when enabled
        base = vcount;
        in_n = 8'h7F;
        step(6);
        check("7f_valid", 32'(valid), 32'd1);
        check("7f_code", 32'(code), 32'd7);
        step(35);
`ifdef ENC_REPEAT_EN
        check("7f_count", 32'(vcount - base), 32'd5);
`else
        check("7f_count", 32'(vcount - base), 32'd1);
`endif
        check("7f_code_end", 32'(code), 32'd7);
        in_n = 8'hFF;
        step(8);
        check("7f_released", 32'(held), 32'd0);
        check("no_back_to_back", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
